name_field_arbiter: RTL and testbench

Output scheduler for the name-line compression stage. It collects the compressed words that the per-field compressors produce in parallel and serializes them onto one shared output port with a valid/ready handshake. Each field has a single-entry holding buffer, and a fair round-robin grant picks which buffer drains next. The block also marks the word that completes a full name line and flags any field whose buffer was overwritten before it drained.

---
 rtl/name_field_arbiter.sv | 172 +++++++++++++++++
 tb/tb_name_field_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/name_field_arbiter.sv
// name_field_arbiter
//   Serializes compressed words from NUM_FIELDS parallel field compressors
//   onto one valid/ready output port. Each field owns a one-entry holding
//   buffer; a round-robin pointer picks the next buffer to drain. The word
//   that completes a full name line (every field seen once) carries out_last.
//   A field rewritten before it drained raises a sticky overflow bit.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   field_data   NUM_FIELDS*DATA_W concatenated words, field i at [i*DATA_W +: DATA_W]
//   field_w      per-field write strobes
//   out_data     serialized word
//   out_field    source field of out_data
//   out_last     word completes the current name line
//   out_valid    output slot holds a word
//   out_ready    consumer accepts the word on valid && ready
//   overflow     sticky per-field overrun flags

// Per-field holding buffer: one data register, a pending flag and the
// sticky overrun flag.
module name_field_slot #(
    parameter int DATA_W = 160
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              grant,
    output logic [DATA_W-1:0] hold_data,
    output logic              pend,
    output logic              ovf
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        data_d = wr ? wdata : data_q;
        // A write in the grant cycle refills the buffer, so pend stays set.
        pend_d = wr | (pend_q & ~grant);
        // Overrun only when the pending word is lost, not when it is drained
        // in the same cycle as the new write.
        ovf_d  = ovf_q | (wr & pend_q & ~grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign hold_data = data_q;
    assign pend      = pend_q;
    assign ovf       = ovf_q;
endmodule

module name_field_arbiter #(
    parameter int NUM_FIELDS = 10,
    parameter int DATA_W     = 160,
    parameter int IDX_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FIELDS*DATA_W-1:0] field_data,
    input  logic [NUM_FIELDS-1:0]        field_w,
    output logic [DATA_W-1:0]            out_data,
    output logic [IDX_W-1:0]             out_field,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS-1:0]        overflow
);
    logic [NUM_FIELDS-1:0][DATA_W-1:0] hold_data;
    logic [NUM_FIELDS-1:0]             pend;
    logic [NUM_FIELDS-1:0]             grant_vec;

    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0]      out_field_q, out_field_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [NUM_FIELDS-1:0] seen_q, seen_d;

    logic                  slot_free;
    logic                  grant_vld;
    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_FIELDS-1:0] seen_set;

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_slot
        name_field_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .wr        (field_w[i]),
            .wdata     (field_data[i*DATA_W +: DATA_W]),
            .grant     (grant_vec[i]),
            .hold_data (hold_data[i]),
            .pend      (pend[i]),
            .ovf       (overflow[i])
        );
    end

    assign slot_free = ~out_valid_q | out_ready;

    // Round-robin search: first pending field at or after rr, with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (slot_free && !grant_vld && pend[(int'(rr_q) + k) % NUM_FIELDS]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'((int'(rr_q) + k) % NUM_FIELDS);
            end
        end
        grant_vec = grant_vld ? (NUM_FIELDS'(1) << grant_idx) : '0;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_field_d = out_field_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        rr_d        = rr_q;
        seen_d      = seen_q;
        seen_set    = seen_q | grant_vec;
        if (grant_vld) begin
            out_data_d  = hold_data[grant_idx];
            out_field_d = grant_idx;
            out_valid_d = 1'b1;
            rr_d        = (grant_idx == IDX_W'(NUM_FIELDS - 1)) ? '0 : grant_idx + 1'b1;
            if (&seen_set) begin
                out_last_d = 1'b1;
                seen_d     = '0;
            end else begin
                out_last_d = 1'b0;
                seen_d     = seen_set;
            end
        end else if (slot_free) begin
            // Nothing to send: drop valid, data/field simply hold.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_field_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rr_q        <= '0;
            seen_q      <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_field_q <= out_field_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            rr_q        <= rr_d;
            seen_q      <= seen_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_field = out_field_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_name_field_arbiter.sv
module tb_name_field_arbiter;
    localparam int NF = 10;
    localparam int DW = 160;
    localparam int IW = 4;

    logic                 clk;
    logic                 rst;
    logic [NF*DW-1:0]     field_data;
    logic [NF-1:0]        field_w;
    logic [DW-1:0]        out_data;
    logic [IW-1:0]        out_field;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [NF-1:0]        overflow;

    int checks = 0;
    int errors = 0;

    name_field_arbiter #(.NUM_FIELDS(NF), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .field_data (field_data),
        .field_w    (field_w),
        .out_data   (out_data),
        .out_field  (out_field),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_field(input int i, input logic [DW-1:0] v);
        field_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        field_w = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        field_w = '0;
        field_data = '0;
        out_ready = 1'b1;
        tick();
        check("rst_valid", DW'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_field", DW'(out_field), 0);
        check("rst_last", DW'(out_last), 0);
        check("rst_ovf", DW'(overflow), 0);
        rst = 1'b0;

        // Single field: two edges from strobe to valid output.
        set_field(3, 'hA5);
        field_w = 10'b0000001000;
        tick();
        field_w = '0;
        check("single_lat1_valid", DW'(out_valid), 0);
        tick();
        check("single_valid", DW'(out_valid), 1);
        check("single_field", DW'(out_field), 3);
        check("single_data", out_data, 'hA5);
        check("single_last", DW'(out_last), 0);
        check("single_ovf", DW'(overflow), 0);
        tick();
        check("single_drain", DW'(out_valid), 0);

        // All fields at once: order 0..9, last on 9.
        do_reset();
        for (int i = 0; i < NF; i++) set_field(i, DW'(i));
        field_w = '1;
        tick();
        field_w = '0;
        for (int i = 0; i < NF; i++) begin
            tick();
            check("all_valid", DW'(out_valid), 1);
            check("all_field", DW'(out_field), DW'(i));
            check("all_data", out_data, DW'(i));
            check("all_last", DW'(out_last), DW'(i == NF - 1));
        end
        tick();
        check("all_drop", DW'(out_valid), 0);

        // Fairness: grant 5, then 2 and 7 together -> 7 first.
        set_field(5, 'h55);
        field_w = 10'b0000100000;
        tick();
        field_w = '0;
        tick();
        check("rr_f5", DW'(out_field), 5);
        set_field(2, 'h22);
        set_field(7, 'h77);
        field_w = 10'b0010000100;
        tick();
        field_w = '0;
        check("rr_gap", DW'(out_valid), 0);
        tick();
        check("rr_first", DW'(out_field), 7);
        check("rr_first_d", out_data, 'h77);
        tick();
        check("rr_second", DW'(out_field), 2);
        check("rr_second_d", out_data, 'h22);
        tick();
        check("rr_idle", DW'(out_valid), 0);

        // Backpressure and overflow on field 4.
        do_reset();
        out_ready = 1'b0;
        set_field(4, 'h11);
        field_w = 10'b0000010000;
        tick();
        field_w = '0;
        tick();
        check("bp_slot", out_data, 'h11);
        set_field(4, 'h22);
        field_w = 10'b0000010000;
        tick();
        check("bp_no_ovf", DW'(overflow), 0);
        set_field(4, 'h33);
        tick();
        field_w = '0;
        check("bp_ovf", DW'(overflow), 'h010);
        check("bp_hold_d", out_data, 'h11);
        check("bp_hold_v", DW'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        check("bp_next_d", out_data, 'h33);
        check("bp_next_f", DW'(out_field), 4);
        tick();
        check("bp_empty", DW'(out_valid), 0);
        check("bp_ovf_sticky", DW'(overflow), 'h010);

        // Grant collision on field 2.
        do_reset();
        set_field(2, 'hAA);
        field_w = 10'b0000000100;
        tick();
        set_field(2, 'hBB);
        tick();
        field_w = '0;
        check("col_first", out_data, 'hAA);
        check("col_ovf", DW'(overflow), 0);
        tick();
        check("col_second_v", DW'(out_valid), 1);
        check("col_second", out_data, 'hBB);
        tick();
        check("col_empty", DW'(out_valid), 0);
        check("col_ovf_end", DW'(overflow), 0);

        // Reset mid-stream with a word in the slot and 3 pends.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < NF; i++) set_field(i, DW'(i + 'h40));
        field_w = 10'b0000101011;
        tick();
        field_w = '0;
        tick();
        check("mid_valid", DW'(out_valid), 1);
        check("mid_field", DW'(out_field), 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", DW'(out_valid), 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_field", DW'(out_field), 0);
        check("mid_rst_last", DW'(out_last), 0);
        check("mid_rst_ovf", DW'(overflow), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_quiet", DW'(out_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
